// File: rtl/ask_pkg.sv
// Shared constants and types for the ASK modem. The modulator bench uses the
// same symbol length, widths and decision threshold.
package ask_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int SYMBOL_LEN = 64;
    localparam int CNT_W      = $clog2(SYMBOL_LEN);
    localparam int ACC_W      = SAMPLE_W + CNT_W;

    // A symbol decodes as 1 when its summed magnitude is strictly above this.
    localparam logic [ACC_W-1:0] THRESHOLD = ACC_W'(100000);

    typedef enum logic {
        IDLE,
        ACCUM
    } demod_state_t;

endpackage

// File: rtl/sample_abs.sv
// Combinational magnitude of a signed sample. The result is unsigned and the
// same width as the input, so the most negative value maps to 2^(W-1).
module sample_abs
    import ask_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic        [SAMPLE_W-1:0] magnitude
);

    // Two's-complement negation wraps -2^(W-1) onto itself, and that bit
    // pattern read as unsigned is exactly the wanted magnitude.
    assign magnitude = sample[SAMPLE_W-1] ? SAMPLE_W'(-sample) : SAMPLE_W'(sample);

endmodule

// File: rtl/ask_demodulator.sv
// Non-coherent ASK demodulator: integrates |sample| over each symbol and
// thresholds the sum to recover one data bit per symbol.
module ask_demodulator
    import ask_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sym_sync,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic        [ACC_W-1:0]    energy,
    output logic                       busy
);

    demod_state_t         state;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic [SAMPLE_W-1:0]  mag;
    logic [ACC_W-1:0]     total;

    sample_abs u_sample_abs (
        .sample    (sample_in),
        .magnitude (mag)
    );

    // ACC_W covers SYMBOL_LEN * 2^(SAMPLE_W-1), so this sum never wraps.
    assign total = acc + ACC_W'(mag);

    // The counter is only non-zero while accumulating.
    assign busy = (state == ACCUM) && (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            energy    <= '0;
        end else begin
            bit_valid <= 1'b0;
            if (sym_sync) begin
                // Resync wins over completion; a coincident sample opens the new symbol.
                if (sample_valid) begin
                    state <= ACCUM;
                    acc   <= ACC_W'(mag);
                    cnt   <= CNT_W'(1);
                end else begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                end
            end else if (sample_valid) begin
                state <= ACCUM;
                if (cnt == CNT_W'(SYMBOL_LEN - 1)) begin
                    energy    <= total;
                    bit_out   <= (total > THRESHOLD);
                    bit_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= total;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ask_demodulator.sv
// Directed and randomized bench for ask_demodulator against an arithmetic
// reference of the symbol-integration rules.
module tb_ask_demodulator;
    import ask_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [15:0]  sample_in = '0;
    logic                sample_valid = 1'b0;
    logic                sym_sync = 1'b0;
    logic                bit_out;
    logic                bit_valid;
    logic [ACC_W-1:0]    energy;
    logic                busy;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     pulses = 0;
    int     last_pulse = -1;
    int     bits_q[$];
    int     pulse_cyc_q[$];

    // Reference: samples taken so far in the current symbol and their magnitude sum.
    int     m_n = 0;
    longint m_sum = 0;
    longint m_energy = 0;
    int     m_bit = 0;

    ask_demodulator dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sym_sync     (sym_sync),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .energy       (energy),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic longint magof(input logic signed [15:0] s);
        longint x;
        x = longint'(s);
        return (x < 0) ? -x : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_sum = 0;
        m_energy = 0;
        m_bit = 0;
    endtask

    task automatic step(input logic signed [15:0] s, input logic v, input logic sy);
        int exp_valid;
        exp_valid = 0;
        sample_in    = s;
        sample_valid = v;
        sym_sync     = sy;
        @(posedge clk);
        #1;
        cyc++;
        if (sy) begin
            m_n = v ? 1 : 0;
            m_sum = v ? magof(s) : 0;
        end else if (v) begin
            m_sum += magof(s);
            m_n++;
            if (m_n == SYMBOL_LEN) begin
                exp_valid = 1;
                m_energy = m_sum;
                m_bit = (m_sum > 100000) ? 1 : 0;
                m_n = 0;
                m_sum = 0;
            end
        end
        chk("bit_valid", 32'(bit_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(m_n != 0));
        chk("energy", 32'(energy), 32'(m_energy));
        chk("bit_out", 32'(bit_out), 32'(m_bit));
        if (bit_valid === 1'b1) begin
            pulses++;
            last_pulse = cyc;
            bits_q.push_back(int'(bit_out));
            pulse_cyc_q.push_back(cyc);
        end
    endtask

    // Simple ASK source: square carrier, large amplitude for 1, small for 0.
    function automatic logic signed [15:0] mod_sample(input int din, input int ph);
        int a;
        a = (din != 0) ? 24000 : 300;
        return 16'(((ph / 4) % 2 == 0) ? a : -a);
    endfunction

    initial begin
        int p0;
        int need;
        int last_valid;
        longint exp_e;
        logic signed [15:0] s;
        logic v;
        int amp;
        int pattern[4];
        pattern = '{1, 0, 1, 1};

        // Reset held with live input traffic: everything stays at zero.
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample_in = 16'($urandom);
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_bit_valid", 32'(bit_valid), 32'd0);
            chk("rst_bit_out", 32'(bit_out), 32'd0);
            chk("rst_energy", 32'(energy), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        sample_valid = 1'b0;
        rst = 1'b0;
        model_reset();

        // Largest positive sample for a whole symbol.
        p0 = pulses;
        for (int i = 0; i < SYMBOL_LEN; i++) step(16'sh7FFF, 1'b1, 1'b0);
        chk("maxpos_pulses", 32'(pulses - p0), 32'd1);
        chk("maxpos_latency", 32'(last_pulse), 32'(cyc));
        chk("maxpos_energy", 32'(energy), 32'd2097088);
        chk("maxpos_bit", 32'(bit_out), 32'd1);

        // Silence, then the most negative sample (full-scale energy, no wrap).
        for (int i = 0; i < SYMBOL_LEN; i++) step(16'sh0000, 1'b1, 1'b0);
        chk("zero_energy", 32'(energy), 32'd0);
        chk("zero_bit", 32'(bit_out), 32'd0);
        for (int i = 0; i < SYMBOL_LEN; i++) step(16'sh8000, 1'b1, 1'b0);
        chk("minneg_energy", 32'(energy), 32'd2097152);
        chk("minneg_bit", 32'(bit_out), 32'd1);

        // Modulated pattern 1,0,1,1, phase aligned, back to back.
        bits_q.delete();
        pulse_cyc_q.delete();
        for (int b = 0; b < 4; b++)
            for (int ph = 0; ph < SYMBOL_LEN; ph++)
                step(mod_sample(pattern[b], ph), 1'b1, 1'b0);
        chk("pattern_count", 32'(bits_q.size()), 32'd4);
        for (int b = 0; b < 4 && b < bits_q.size(); b++)
            chk("pattern_bit", 32'(bits_q[b]), 32'(pattern[b]));
        for (int b = 1; b < pulse_cyc_q.size(); b++)
            chk("pattern_spacing", 32'(pulse_cyc_q[b] - pulse_cyc_q[b-1]), 32'(SYMBOL_LEN));

        // 64 valid samples scattered over 100 cycles.
        p0 = pulses;
        need = SYMBOL_LEN;
        exp_e = 0;
        last_valid = -1;
        for (int c = 0; c < 100; c++) begin
            v = (need > 0) && ((need >= 100 - c) || ($urandom_range(0, 2) != 0));
            s = 16'($urandom);
            if (v) begin
                exp_e += magof(s);
                need--;
            end
            step(s, v, 1'b0);
            if (v) last_valid = cyc;
        end
        chk("gap_pulses", 32'(pulses - p0), 32'd1);
        chk("gap_latency", 32'(last_pulse), 32'(last_valid));
        chk("gap_energy", 32'(energy), 32'(exp_e));

        // Resync after 30 samples drops the partial symbol.
        p0 = pulses;
        for (int i = 0; i < 30; i++) step(16'($urandom), 1'b1, 1'b0);
        step(16'sh1234, 1'b0, 1'b1);
        chk("sync_busy", 32'(busy), 32'd0);
        chk("sync_no_pulse", 32'(pulses - p0), 32'd0);

        // Resync with a coincident sample: decision after 63 more samples.
        step(16'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < SYMBOL_LEN - 2; i++) step(16'($urandom), 1'b1, 1'b0);
        chk("sync_sample_early", 32'(pulses - p0), 32'd0);
        step(16'($urandom), 1'b1, 1'b0);
        chk("sync_sample_pulse", 32'(pulses - p0), 32'd1);
        chk("sync_sample_latency", 32'(last_pulse), 32'(cyc));

        // Resync on what would be the 64th sample suppresses the decision.
        p0 = pulses;
        for (int i = 0; i < SYMBOL_LEN - 1; i++) step(16'($urandom), 1'b1, 1'b0);
        step(16'sh7FFF, 1'b1, 1'b1);
        chk("sync_64_no_pulse", 32'(pulses - p0), 32'd0);
        chk("sync_64_busy", 32'(busy), 32'd1);
        for (int i = 0; i < SYMBOL_LEN - 1; i++) step(16'($urandom), 1'b1, 1'b0);
        chk("sync_64_next_pulse", 32'(pulses - p0), 32'd1);

        // Random traffic with gaps, occasional resyncs and alternating amplitude.
        for (int i = 0; i < 1500; i++) begin
            amp = ((i / 64) % 2 != 0) ? 32767 : 3000;
            s = 16'(int'($urandom_range(0, 2 * amp)) - amp);
            step(s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 96) == 0));
        end

        // Asynchronous reset in the middle of a symbol.
        for (int i = 0; i < 20; i++) step(16'($urandom), 1'b1, 1'b0);
        sample_valid = 1'b0;
        sym_sync = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_energy", 32'(energy), 32'd0);
        chk("arst_bit_out", 32'(bit_out), 32'd0);
        chk("arst_bit_valid", 32'(bit_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        p0 = pulses;
        for (int i = 0; i < SYMBOL_LEN; i++) step(16'sh4000, 1'b1, 1'b0);
        chk("post_rst_pulse", 32'(pulses - p0), 32'd1);
        chk("post_rst_energy", 32'(energy), 32'd1048576);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
